// File: rtl/prnd_mod_gen.sv
// prnd_mod_gen: 16-bit Fibonacci LFSR whose low bits are reduced modulo a
// runtime divisor. The reduction is a bit-serial restoring remainder, so the
// latency is fixed at N+1 clocks from acceptance to the valid pulse. A request
// that arrives in the DONE cycle is held over and started from IDLE, which
// gives a back-to-back period of N+2 clocks.
module prnd_mod_gen #(
    parameter int          NUM_PRND_BITS = 5,         // legal range 2..15
    parameter logic [15:0] LFSR_SEED     = 16'hACE1   // 0 is replaced by 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     advance,
    input  logic [NUM_PRND_BITS:0]   divisor,
    output logic [NUM_PRND_BITS-1:0] prndNumber,
    output logic                     valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int          N         = NUM_PRND_BITS;
    localparam int          RW        = N + 1;   // remainder width
    localparam int          CW        = 4;       // enough to count 15 iterations
    localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // LFSR
    logic [15:0]   lfsr_reg;
    logic [15:0]   lfsr_next;

    // Control
    state_t        state_reg;
    state_t        state_next;
    logic          load_job;
    logic          step_job;
    logic          finish_job;
    logic [CW-1:0] iter_reg;
    logic          pending_reg;

    // Reduction datapath
    logic [N-1:0]  raw_reg;
    logic [RW-1:0] div_reg;
    logic [RW-1:0] rem_reg;
    logic [RW-1:0] rem_next;
    logic [RW:0]   trial;
    logic          trial_ge;

    // Output registers
    logic [N-1:0]  prnd_reg;
    logic          valid_reg;
    logic          overrun_reg;

    // Shift-left part of the LFSR: each bit takes its lower neighbour.
    genvar gi;
    generate
        for (gi = 1; gi < 16; gi++) begin : g_lfsr_shift
            assign lfsr_next[gi] = lfsr_reg[gi-1];
        end
    endgenerate

    // Fibonacci feedback taps 16,14,13,11 enter at the LSB.
    assign lfsr_next[0] = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

    // LFSR register: free-runs while enabled, freezes while disabled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_reg <= SEED_EFF;
        end else if (enable) begin
            lfsr_reg <= lfsr_next;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state and datapath strobes; disabling aborts any job.
    always_comb begin
        state_next = state_reg;
        load_job   = 1'b0;
        step_job   = 1'b0;
        finish_job = 1'b0;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (advance || pending_reg) begin
                        load_job   = 1'b1;
                        state_next = REDUCE;
                    end
                end
                REDUCE: begin
                    step_job = 1'b1;
                    if (iter_reg == LAST_ITER) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    finish_job = 1'b1;
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // One restoring step: bring in the next raw bit, subtract if it fits.
    always_comb begin
        trial    = {rem_reg, raw_reg[N-1]};
        trial_ge = (trial >= {1'b0, div_reg});
        rem_next = trial_ge ? RW'(trial - {1'b0, div_reg}) : trial[RW-1:0];
    end

    // Reduction datapath: capture operands on acceptance, then one bit per clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            raw_reg  <= '0;
            div_reg  <= '0;
            rem_reg  <= '0;
            iter_reg <= '0;
        end else if (load_job) begin
            raw_reg  <= lfsr_reg[N-1:0];
            div_reg  <= divisor;
            rem_reg  <= '0;
            iter_reg <= '0;
        end else if (step_job) begin
            raw_reg  <= raw_reg << 1;
            rem_reg  <= rem_next;
            iter_reg <= iter_reg + CW'(1);
        end
    end

    // Result register and valid pulse; a zero divisor yields zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prnd_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= finish_job;
            if (!enable) begin
                prnd_reg <= '0;
            end else if (finish_job) begin
                prnd_reg <= (div_reg == '0) ? '0 : rem_reg[N-1:0];
            end
        end
    end

    // Held-over request from the DONE cycle and the sticky overrun flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_reg <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            pending_reg <= enable && advance && (state_reg == DONE);
            if (enable && advance && (state_reg == REDUCE)) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign prndNumber = prnd_reg;
    assign valid      = valid_reg;
    assign busy       = (state_reg == REDUCE);
    assign overrun    = overrun_reg;

endmodule
